// File: rtl/if_id_buffer.sv
// IF/ID instruction buffer: circular FIFO of {inst, pc} with flush and NOP bubble.
// Optional zero-latency empty-buffer bypass enabled by defining IF_ID_BYPASS_EN.
module if_id_buffer #(
    parameter int unsigned       DEPTH    = 4,
    parameter int unsigned       INST_W   = 32,
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [INST_W-1:0] NOP_INST = 32'h00000013
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid_i,
    input  logic [INST_W-1:0]          in_inst_i,
    input  logic [ADDR_W-1:0]          in_addr_i,
    output logic                       in_ready_o,
    input  logic                       flush_i,
    input  logic                       stall_i,
    output logic                       out_valid_o,
    output logic [INST_W-1:0]          out_inst_o,
    output logic [ADDR_W-1:0]          out_addr_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int unsigned      PTR_W = $clog2(DEPTH);
    localparam int unsigned      CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

    logic [INST_W-1:0] inst_q [DEPTH];
    logic [ADDR_W-1:0] addr_q [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic empty, full, bypass, push, pop;

    always_comb begin
        empty = (count_q == '0);
        full  = (count_q == FULL);
`ifdef IF_ID_BYPASS_EN
        bypass = empty & in_valid_i & ~flush_i;
`else
        bypass = 1'b0;
`endif
        // A bypassed instruction that decode takes right away is never stored
        push = in_valid_i & ~full & ~flush_i & ~(bypass & ~stall_i);
        pop  = ~empty & ~stall_i & ~flush_i;
    end

    always_comb begin
        in_ready_o  = ~full;
        count_o     = count_q;
        out_valid_o = ~empty | bypass;
        out_inst_o  = NOP_INST;
        out_addr_o  = '0;
        if (!empty) begin
            out_inst_o = inst_q[rd_ptr_q];
            out_addr_o = addr_q[rd_ptr_q];
        end else if (bypass) begin
            out_inst_o = in_inst_i;
            out_addr_o = in_addr_i;
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            inst_q[wr_ptr_q] <= in_inst_i;
            addr_q[wr_ptr_q] <= in_addr_i;
        end
    end
endmodule

// File: tb/tb_if_id_buffer.sv
// Self-checking bench for if_id_buffer against a queue-based reference model.
// Honours IF_ID_BYPASS_EN in the model when the macro is defined.
module tb_if_id_buffer;
    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h00000013;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] addr;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid_i = 1'b0;
    logic [31:0] in_inst_i = '0;
    logic [31:0] in_addr_i = '0;
    logic        in_ready_o;
    logic        flush_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        out_valid_o;
    logic [31:0] out_inst_o;
    logic [31:0] out_addr_o;
    logic [2:0]  count_o;

    int   n_chk = 0;
    int   n_pass = 0;
    ent_t q[$];

    if_id_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid_i), .in_inst_i(in_inst_i),
        .in_addr_i(in_addr_i), .in_ready_o(in_ready_o),
        .flush_i(flush_i), .stall_i(stall_i),
        .out_valid_o(out_valid_o), .out_inst_o(out_inst_o),
        .out_addr_o(out_addr_o), .count_o(count_o)
    );

    always #5 clk = ~clk;

    function automatic bit byp_now();
`ifdef IF_ID_BYPASS_EN
        return q.size() == 0 && in_valid_i && !flush_i;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic exp_valid();
        return q.size() != 0 || byp_now();
    endfunction

    function automatic logic [31:0] exp_inst();
        if (q.size() != 0) return q[0].inst;
        if (byp_now()) return in_inst_i;
        return NOP;
    endfunction

    function automatic logic [31:0] exp_addr();
        if (q.size() != 0) return q[0].addr;
        if (byp_now()) return in_addr_i;
        return 32'h0;
    endfunction

    task automatic apply(input logic v, input logic [31:0] inst,
                         input logic [31:0] addr, input logic st,
                         input logic fl);
        in_valid_i = v;
        in_inst_i  = inst;
        in_addr_i  = addr;
        stall_i    = st;
        flush_i    = fl;
        #1;
    endtask

    task automatic tick();
        bit acc, pp, direct;
        ent_t e;
        acc    = in_valid_i && q.size() < DEPTH && !flush_i;
        pp     = q.size() != 0 && !stall_i && !flush_i;
        direct = byp_now() && !stall_i;
        e.inst = in_inst_i;
        e.addr = in_addr_i;
        @(posedge clk);
        if (flush_i) q.delete();
        else begin
            if (pp) void'(q.pop_front());
            if (acc && !direct) q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        n_chk++;
        if (out_valid_o !== 1'b0 || out_inst_o !== NOP || out_addr_o !== 32'h0)
            $display("FAIL reset_out: got v=%b i=%h a=%h want v=0 i=%h a=0",
                     out_valid_o, out_inst_o, out_addr_o, NOP);
        else n_pass++;
        rst_n = 1'b1;
        apply(0, 0, 0, 0, 0);
        n_chk++;
        if (count_o !== 3'd0 || in_ready_o !== 1'b1)
            $display("FAIL reset_cnt: got c=%0d r=%b want c=0 r=1", count_o, in_ready_o);
        else n_pass++;
    endtask

    task automatic test_single();
        apply(1, 32'h00100093, 32'h80000000, 0, 0);
        tick();
        apply(0, 0, 0, 0, 0);
        n_chk++;
        if (out_valid_o !== exp_valid() || out_inst_o !== exp_inst() ||
            out_addr_o !== exp_addr())
            $display("FAIL single_out: got v=%b i=%h a=%h want v=%b i=%h a=%h",
                     out_valid_o, out_inst_o, out_addr_o,
                     exp_valid(), exp_inst(), exp_addr());
        else n_pass++;
        tick();
        n_chk++;
        if (out_valid_o !== 1'b0 || out_inst_o !== NOP)
            $display("FAIL single_empty: got v=%b i=%h want v=0 i=%h",
                     out_valid_o, out_inst_o, NOP);
        else n_pass++;
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 4; i++) begin
            apply(1, 32'h1000 + i, 32'h80000000 + 4 * i, 1, 0);
            tick();
        end
        apply(1, 32'h2000, 32'h80000010, 1, 0);
        n_chk++;
        if (count_o !== 3'd4 || in_ready_o !== 1'b0)
            $display("FAIL fill_full: got c=%0d r=%b want c=4 r=0", count_o, in_ready_o);
        else n_pass++;
        tick();
        n_chk++;
        if (count_o !== 3'd4)
            $display("FAIL fill_5th: got c=%0d want c=4", count_o);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            apply(0, 0, 0, 0, 0);
            n_chk++;
            if (out_valid_o !== 1'b1 || out_addr_o !== 32'h80000000 + 4 * i ||
                out_inst_o !== 32'h1000 + i)
                $display("FAIL drain_%0d: got v=%b a=%h i=%h want v=1 a=%h i=%h",
                         i, out_valid_o, out_addr_o, out_inst_o,
                         32'h80000000 + 4 * i, 32'h1000 + i);
            else n_pass++;
            tick();
        end
        n_chk++;
        if (out_valid_o !== 1'b0 || count_o !== 3'd0)
            $display("FAIL drain_end: got v=%b c=%0d want v=0 c=0", out_valid_o, count_o);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 11; i++) begin
            apply(1, 32'h3000 + i, 32'h80001000 + 4 * i, 0, 0);
            n_chk++;
            if (count_o !== 3'(q.size()) || out_addr_o !== exp_addr() ||
                out_valid_o !== exp_valid())
                $display("FAIL b2b_%0d: got c=%0d a=%h v=%b want c=%0d a=%h v=%b",
                         i, count_o, out_addr_o, out_valid_o,
                         q.size(), exp_addr(), exp_valid());
            else n_pass++;
            tick();
        end
        apply(0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            apply(1, 32'h4000 + i, 32'h80002000 + 4 * i, 1, 0);
            tick();
        end
        apply(1, 32'hdeadbeef, 32'h90000000, 1, 1);
        tick();
        apply(0, 0, 0, 0, 0);
        n_chk++;
        if (count_o !== 3'd0 || out_valid_o !== 1'b0 || in_ready_o !== 1'b1)
            $display("FAIL flush_state: got c=%0d v=%b r=%b want c=0 v=0 r=1",
                     count_o, out_valid_o, in_ready_o);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (out_valid_o !== 1'b0 || out_addr_o === 32'h90000000)
                $display("FAIL flush_leak_%0d: got v=%b a=%h want v=0 a=0",
                         i, out_valid_o, out_addr_o);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_full_pop();
        for (int i = 0; i < 4; i++) begin
            apply(1, 32'h5000 + i, 32'h80003000 + 4 * i, 1, 0);
            tick();
        end
        apply(1, 32'h5555, 32'h80003010, 0, 0);
        n_chk++;
        if (in_ready_o !== 1'b0)
            $display("FAIL fullpop_rdy: got r=%b want r=0", in_ready_o);
        else n_pass++;
        tick();
        apply(0, 0, 0, 1, 0);
        n_chk++;
        if (count_o !== 3'd3 || in_ready_o !== 1'b1 || out_addr_o !== 32'h80003004)
            $display("FAIL fullpop_next: got c=%0d r=%b a=%h want c=3 r=1 a=80003004",
                     count_o, in_ready_o, out_addr_o);
        else n_pass++;
        apply(0, 0, 0, 0, 1);
        tick();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 2; i++) begin
            apply(1, 32'h6000 + i, 32'h80004000 + 4 * i, 1, 0);
            tick();
        end
        apply(0, 0, 0, 1, 0);
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        n_chk++;
        if (out_valid_o !== 1'b0 || out_inst_o !== NOP || out_addr_o !== 32'h0 ||
            count_o !== 3'd0 || in_ready_o !== 1'b1)
            $display("FAIL async_rst: got v=%b i=%h a=%h c=%0d r=%b want v=0 i=%h a=0 c=0 r=1",
                     out_valid_o, out_inst_o, out_addr_o, count_o, in_ready_o, NOP);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

`ifdef IF_ID_BYPASS_EN
    task automatic test_bypass();
        apply(1, 32'h00200113, 32'h80005000, 0, 0);
        n_chk++;
        if (out_valid_o !== 1'b1 || out_inst_o !== 32'h00200113 ||
            out_addr_o !== 32'h80005000 || count_o !== 3'd0)
            $display("FAIL bypass_out: got v=%b i=%h a=%h c=%0d want v=1 i=00200113 a=80005000 c=0",
                     out_valid_o, out_inst_o, out_addr_o, count_o);
        else n_pass++;
        tick();
        apply(0, 0, 0, 0, 0);
        n_chk++;
        if (count_o !== 3'd0 || out_valid_o !== 1'b0)
            $display("FAIL bypass_next: got c=%0d v=%b want c=0 v=0", count_o, out_valid_o);
        else n_pass++;
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            apply(1'($urandom_range(0, 1)), $urandom, $urandom,
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 15) == 0));
            n_chk++;
            if (out_valid_o !== exp_valid() || out_inst_o !== exp_inst() ||
                out_addr_o !== exp_addr() || count_o !== 3'(q.size()) ||
                in_ready_o !== (q.size() < DEPTH))
                $display("FAIL rand_%0d: got v=%b i=%h a=%h c=%0d r=%b want v=%b i=%h a=%h c=%0d r=%b",
                         i, out_valid_o, out_inst_o, out_addr_o, count_o, in_ready_o,
                         exp_valid(), exp_inst(), exp_addr(), q.size(), q.size() < DEPTH);
            else n_pass++;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_drain();
        test_back_to_back();
        test_flush();
        test_full_pop();
        test_async_reset();
`ifdef IF_ID_BYPASS_EN
        test_bypass();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/if_id_buffer.md
Name: if_id_buffer

Overview:
- Instruction fetch buffer between the fetch stage (ifu) and the decode stage (idu).
- Holds fetched {inst, pc} pairs in a small circular FIFO, so decode-side stalls do not drop fetched instructions.
- Presents a NOP bubble to decode when empty.
- Drives backpressure to the fetch stage.
- Supports single-cycle flush on branch mispredict or exception.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, >= 2.
- INST_W, 32, instruction width.
- ADDR_W, 32, instruction address width.
- NOP_INST, 32'h00000013, bubble instruction (addi x0,x0,0) driven when the buffer is empty.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid_i  in  1  fetch stage presents a valid instruction.
- in_inst_i  in  INST_W  fetched instruction.
- in_addr_i  in  ADDR_W  pc of the fetched instruction.
- in_ready_o  out  1  buffer can accept; fetch stage must hold pc when low.
- flush_i  in  1  discard all buffered and incoming instructions.
- stall_i  in  1  decode stage not consuming this cycle.
- out_valid_o  out  1  out_inst_o / out_addr_o hold a real instruction.
- out_inst_o  out  INST_W  head instruction, or NOP_INST when not valid.
- out_addr_o  out  ADDR_W  head pc, or 0 when not valid.
- count_o  out  log2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (async, rst_n low):
  - rd_ptr = wr_ptr = 0, count = 0.
  - Outputs: out_valid_o=0, out_inst_o=NOP_INST, out_addr_o=0, in_ready_o=1, count_o=0.
  - Entry storage is not reset.
- Reset asserted mid-operation discards all contents immediately.
- push = in_valid_i & in_ready_o & ~flush_i.
- pop = out_valid_o & ~stall_i & ~flush_i.
- in_ready_o = (count != DEPTH). It depends only on registered count, never combinationally on stall_i.
- On push: entry[wr_ptr] <= {in_inst_i, in_addr_i}; wr_ptr <= wr_ptr+1 mod DEPTH.
- On pop: rd_ptr <= rd_ptr+1 mod DEPTH.
- Count update:
  - push & pop: count unchanged.
  - push only: count+1.
  - pop only: count-1.
- Pointers wrap naturally at DEPTH; count disambiguates full from empty.
- Full (count==DEPTH):
  - in_ready_o=0 and no push, even if a pop happens in the same cycle.
  - No pass-through when full; in_ready_o rises the cycle after the pop.
- Empty (count==0):
  - out_valid_o=0 and pop is impossible.
  - Outputs show NOP_INST / addr 0.
- Output is combinational from entry[rd_ptr] when count!=0.
- Latency with the optional feature off: an instruction pushed in cycle N is visible at the output in cycle N+1.
- Flush (flush_i=1):
  - Next edge: rd_ptr <= 0, wr_ptr <= 0, count <= 0.
  - Any same-cycle push is dropped; no pop is counted.
  - flush_i has priority over stall_i and in_valid_i.
  - Cycle after flush: buffer is empty, in_ready_o=1.
- stall_i with empty buffer: no effect.
- stall_i with a non-empty buffer: head and outputs stay stable.

Optional Feature:
- Macro: IF_ID_BYPASS_EN.
- Defined, when count==0 & in_valid_i & ~flush_i:
  - out_valid_o=1 and outputs show in_inst_i / in_addr_i combinationally.
  - If also ~stall_i, the instruction is consumed directly: no write, pointers and count unchanged.
  - If stall_i, it is written normally.
  - Gives zero-cycle latency when empty.
- Not defined: no bypass, fixed 1-cycle latency as above.

Test Plan:
- Reset, then push inst 32'h00100093 @ pc 32'h80000000, stall_i=0:
  - Next cycle out_valid_o=1 with that inst/pc.
  - Following cycle empty again, out_inst_o=32'h00000013.
- Hold stall_i=1 and push 4 instrs at pc 0x80000000..0x8000000C:
  - count_o reaches 4 and in_ready_o=0.
  - A 5th in_valid_i is not accepted.
  - Release stall: pops occur in order 0x80000000, 0x80000004, 0x80000008, 0x8000000C.
- Continuous push+pop for 10 cycles:
  - Pointers wrap and count_o stays at 1.
  - PC order is preserved across the wrap.
- With 3 entries buffered, assert flush_i together with in_valid_i:
  - Next cycle count_o=0, out_valid_o=0, in_ready_o=1.
  - The flushed-cycle instruction never appears at the output.
- Full buffer with pop and in_valid_i in the same cycle:
  - No push that cycle; count_o=3.
  - in_ready_o=1 next cycle.
- Assert rst_n=0 asynchronously mid-cycle with 2 entries buffered:
  - Outputs go immediately to reset values and count_o=0.
  - With IF_ID_BYPASS_EN defined: push into an empty buffer with stall_i=0 shows the instruction at the output in the same cycle, and count_o stays 0.
